// File: rtl/boot_store_pkg.sv
// Shared types, default boot image and address helpers for boot_store.
package boot_store_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_DATA_W    = 16;
  localparam int unsigned DEFAULT_ROM_WORDS = 7;

  // Word 0 sits in the LSBs.
  localparam logic [DEFAULT_ROM_WORDS*DEFAULT_DATA_W-1:0] DEFAULT_BOOT_IMAGE = {
    16'h4000, 16'h3007, 16'hF400, 16'h1007, 16'hF800, 16'h4000, 16'hF200
  };

  // True when a word address falls inside the read-only boot image.
  function automatic logic is_rom(input logic [31:0] addr, input int unsigned rom_words);
    return addr < rom_words;
  endfunction

endpackage

// File: rtl/boot_store_array.sv
// Scratch word storage: one synchronous write port, one combinational read port.
// No reset on purpose; the owner clears the contents with a sequenced pass.
module boot_store_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/boot_store.sv
// Boot memory: constant boot image in the low words, writable scratch above,
// cleared by an INIT pass after every reset before rdy is raised.
module boot_store
  import boot_store_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ROM_WORDS = DEFAULT_ROM_WORDS,
  parameter logic [ROM_WORDS*DATA_W-1:0] BOOT_IMAGE = DEFAULT_BOOT_IMAGE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rdy,
  output logic              wr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  if (ROM_WORDS < 1 || ROM_WORDS > DEPTH) begin : g_bad_rom_words
    $error("boot_store: ROM_WORDS must be in 1..DEPTH");
  end

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic              wr_err_q, wr_err_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [DATA_W-1:0] rom_word_c;
  logic              rom_hit_c;
  logic [DATA_W-1:0] rd_word_c;

  boot_store_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .we_i      (mem_we_c),
    .waddr_i   (mem_waddr_c),
    .wdata_i   (mem_wdata_c),
    .raddr_i   (addr),
    .rdata_c_o (mem_rdata_c)
  );

  // Constant boot image lookup; no flops behind these words.
  always_comb begin
    rom_word_c = '0;
    for (int unsigned i = 0; i < ROM_WORDS; i++) begin
      if (addr == ADDR_W'(i)) begin
        rom_word_c = BOOT_IMAGE[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rom_hit_c = is_rom(32'(addr), ROM_WORDS);
  assign rd_word_c = rom_hit_c ? rom_word_c : mem_rdata_c;

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_ptr_q <= PTR_W'(ROM_WORDS);
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Next-state: INIT clears scratch word by word, IDLE serves the bus.
  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    dout_d      = dout_q;
    wr_err_d    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = addr;
    mem_wdata_c = din;

    case (state_q)
      INIT: begin
        // With no scratch words the pointer starts at DEPTH and no write is issued.
        if (init_ptr_q < PTR_W'(DEPTH)) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = init_ptr_q[ADDR_W-1:0];
          mem_wdata_c = '0;
        end
        init_ptr_d = init_ptr_q + PTR_W'(1);
        if (init_ptr_q >= PTR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs) begin
          if (we) begin
            if (rom_hit_c) begin
              wr_err_d = 1'b1;
            end else begin
              mem_we_c = 1'b1;
            end
          end else begin
            dout_d = rd_word_c;
          end
        end
      end
      default: state_d = INIT;
    endcase

    rdy_d = (state_d == IDLE);
  end

  assign dout   = dout_q;
  assign rdy    = rdy_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_boot_store.sv
// Scoreboard bench for boot_store with the default 16x16, 7-word boot image.
module tb_boot_store;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        rdy;
  logic        wr_err;

  int total;
  int bad;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];
  logic [15:0] rom_tbl [7];

  boot_store dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .rdy    (rdy),
    .wr_err (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = (i < 7) ? rom_tbl[i] : 16'h0000;
  endtask

  // Drive one read cycle and push the expected data for the following sample.
  task automatic issue_read(input logic [3:0] a);
    exp_q.push_back(model[a]);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic issue_write(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    if (a >= 4'd7) model[a] = d;
  endtask

  task automatic wait_rdy(output int cycles);
    cycles = 0;
    while (!rdy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dout !== 16'h0000 || rdy !== 1'b0 || wr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs dout=%h rdy=%b wr_err=%b want 0000/0/0", dout, rdy, wr_err);
    end
    rst_n = 1'b1;
    model_reset();
    wait_rdy(cyc);
    total++;
    if (cyc !== 9 || rdy !== 1'b1) begin
      bad++;
      $display("FAIL init_length cycles=%0d rdy=%b want 9/1", cyc, rdy);
    end
  endtask

  task automatic test_read_all();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      issue_read(4'(i));
      exp = exp_q.pop_front();
      total++;
      if (dout !== exp) begin
        bad++;
        $display("FAIL read_all addr=%0h got=%h want=%h", i, dout, exp);
      end
    end
  endtask

  task automatic test_rom_write();
    logic [15:0] exp;
    issue_write(4'h3, 16'hBEEF);
    total++;
    if (wr_err !== 1'b1) begin
      bad++;
      $display("FAIL rom_write_err_pulse got=%b want=1", wr_err);
    end
    @(posedge clk); #1;
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL rom_write_err_clear got=%b want=0", wr_err);
    end
    issue_read(4'h3);
    exp = exp_q.pop_front();
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL rom_write_readback got=%h want=%h", dout, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [15:0] dprev;
    dprev = dout;
    issue_write(4'h7, 16'hABCD);
    total++;
    if (wr_err !== 1'b0 || dout !== dprev) begin
      bad++;
      $display("FAIL b2b_write wr_err=%b dout=%h want 0/%h", wr_err, dout, dprev);
    end
    issue_read(4'h7);
    exp = exp_q.pop_front();
    total++;
    if (dout !== exp || wr_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_read dout=%h wr_err=%b want %h/0", dout, wr_err, exp);
    end
  endtask

  task automatic test_init_ignore();
    int cyc;
    logic [15:0] exp;
    int errs;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    cs = 1'b1; we = 1'b1; addr = 4'h9; din = 16'h1234;
    cyc = 0;
    errs = 0;
    while (!rdy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (wr_err !== 1'b0) errs++;
    end
    cs = 1'b0; we = 1'b0;
    total++;
    if (cyc !== 9 || errs != 0 || dout !== 16'h0000) begin
      bad++;
      $display("FAIL init_ignore cycles=%0d wr_err_hits=%0d dout=%h want 9/0/0000", cyc, errs, dout);
    end
    issue_read(4'h9);
    exp = exp_q.pop_front();
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL init_ignore_read got=%h want=%h", dout, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    logic [15:0] exp;
    issue_write(4'hF, 16'h5555);
    issue_read(4'hF);
    exp = exp_q.pop_front();
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL midrst_prewrite got=%h want=%h", dout, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy !== 1'b0 || dout !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_idle rdy=%b dout=%h want 0/0000", rdy, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_in_init rdy=%b want 0", rdy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy !== 1'b0 || dout !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_init_assert rdy=%b dout=%h want 0/0000", rdy, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_rdy(cyc);
    total++;
    if (cyc !== 9) begin
      bad++;
      $display("FAIL midrst_reinit cycles=%0d want 9", cyc);
    end
    issue_read(4'hF);
    exp = exp_q.pop_front();
    total++;
    if (dout !== exp) begin
      bad++;
      $display("FAIL midrst_readback got=%h want=%h", dout, exp);
    end
  endtask

  initial begin
    rom_tbl = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3007, 16'h4000};
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cs    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    model_reset();

    test_reset();
    test_read_all();
    test_rom_write();
    test_back_to_back();
    test_init_ignore();
    test_reset_mid_op();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
